// File: rtl/reflex_ctrl.sv
// reflex_ctrl - trial sequencer for the reflex-measurement datapath.
//
// Each start pulse in IDLE runs one trial. A pseudo-random pre-light delay
// (DELAY_MIN + masked LFSR bits, in ticks) is followed by the lamp, and the
// reaction time is counted in ticks. A press during the delay is an error:
// the external 2-bit penalty counter is loaded with the new error count,
// decremented every PEN_TICKS ticks, and the trial resumes with a fresh delay
// once that counter reports empty. The fourth early press aborts the trial.
//
// Optional build macro: REFLEX_BEST_EN keeps the best valid reaction time on
// best_rt. Without it best_rt is tied to all-ones.
//
// Ports:
//   ck               clock
//   rst_n            asynchronous active-low reset
//   start            single-cycle trial start request (IDLE only)
//   btn              synchronized, debounced button level
//   end_wait         penalty counter empty flag
//   load_wait        load penalty counter with new_error_count
//   dec_wait         decrement penalty counter
//   new_error_count  value loaded into penalty counter
//   led              stimulus lamp
//   busy             trial in progress
//   done             one-cycle result strobe
//   fail             trial aborted on the fourth early press
//   timeout          no press within TIMEOUT ticks
//   rt               reaction time in ticks (all-ones on timeout)
//   errors           early presses in the current trial
//   best_rt          best valid reaction time since reset
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start
// DELAY  | random pre-light delay running, early press -> PLOAD
// PLOAD  | one cycle: count the error and load the penalty counter, or fail
// PWAIT  | penalty running, dec_wait every PEN_TICKS ticks until end_wait
// LIGHT  | lamp on, reaction time counting
// DONE   | one cycle result strobe

module reflex_ctrl #(
    parameter int          TICK_DIV  = 1000,
    parameter int          DELAY_MIN = 500,
    parameter logic [7:0]  DLY_MASK  = 8'hFF,
    parameter int          PEN_TICKS = 250,
    parameter int          TIME_W    = 12,
    parameter int          TIMEOUT   = 2000,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic              ck,
    input  logic              rst_n,
    input  logic              start,
    input  logic              btn,
    input  logic              end_wait,
    output logic              load_wait,
    output logic              dec_wait,
    output logic [1:0]        new_error_count,
    output logic              led,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic              timeout,
    output logic [TIME_W-1:0] rt,
    output logic [1:0]        errors,
    output logic [TIME_W-1:0] best_rt
);

    localparam int             PRE_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(TICK_DIV - 1);
    localparam int             CNT_W   = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_DELAY, S_PLOAD, S_PWAIT, S_LIGHT, S_DONE
    } state_t;

    state_t            r_state;
    logic [PRE_W-1:0]  r_pre;
    logic [CNT_W-1:0]  r_cnt;      // delay ticks left in DELAY, ticks to next dec_wait in PWAIT
    logic [TIME_W-1:0] r_rtc;
    logic [15:0]       r_lfsr;
    logic              r_btn_q;
    logic              r_first;    // first PWAIT cycle: end_wait still shows the pre-load value

    logic              w_tick;
    logic              w_btn_edge;
    logic              w_cnt_last;
    logic [15:0]       w_lfsr_next;
    logic [CNT_W-1:0]  w_draw;

    assign w_tick      = (r_pre == '0);
    assign w_btn_edge  = btn & ~r_btn_q;
    // Expire on the tick that would take the counter to zero, so a load of N
    // gives exactly N ticks.
    assign w_cnt_last  = (r_cnt <= CNT_W'(1));
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_draw      = CNT_W'(DELAY_MIN) + CNT_W'(r_lfsr[7:0] & DLY_MASK);

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_pre           <= PRE_TOP;
            r_cnt           <= '0;
            r_rtc           <= '0;
            r_lfsr          <= SEED;
            r_btn_q         <= 1'b0;
            r_first         <= 1'b0;
            load_wait       <= 1'b0;
            dec_wait        <= 1'b0;
            new_error_count <= 2'd0;
            led             <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            fail            <= 1'b0;
            timeout         <= 1'b0;
            rt              <= '0;
            errors          <= 2'd0;
        end else begin
            r_btn_q   <= btn;
            r_lfsr    <= w_lfsr_next;
            r_pre     <= w_tick ? PRE_TOP : r_pre - 1'b1;
            load_wait <= 1'b0;
            dec_wait  <= 1'b0;
            done      <= 1'b0;

            // Every transition below also restarts the prescaler.
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_DELAY;
                        r_pre   <= PRE_TOP;
                        r_cnt   <= w_draw;
                        busy    <= 1'b1;
                        errors  <= 2'd0;
                        fail    <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                S_DELAY: begin
                    if (w_btn_edge) begin
                        r_state <= S_PLOAD;
                        r_pre   <= PRE_TOP;
                    end else if (w_tick) begin
                        if (w_cnt_last) begin
                            r_state <= S_LIGHT;
                            r_pre   <= PRE_TOP;
                            r_rtc   <= '0;
                            led     <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_PLOAD: begin
                    r_pre <= PRE_TOP;
                    if (errors == 2'd3) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        fail    <= 1'b1;
                    end else begin
                        r_state         <= S_PWAIT;
                        r_first         <= 1'b1;
                        r_cnt           <= CNT_W'(PEN_TICKS);
                        errors          <= errors + 2'd1;
                        new_error_count <= errors + 2'd1;
                        load_wait       <= 1'b1;
                    end
                end
                S_PWAIT: begin
                    if (!r_first && end_wait) begin
                        r_state <= S_DELAY;
                        r_pre   <= PRE_TOP;
                        r_cnt   <= w_draw;
                    end else begin
                        r_first <= 1'b0;
                        if (w_tick) begin
                            if (w_cnt_last) begin
                                dec_wait <= 1'b1;
                                r_cnt    <= CNT_W'(PEN_TICKS);
                            end else begin
                                r_cnt <= r_cnt - 1'b1;
                            end
                        end
                    end
                end
                S_LIGHT: begin
                    if (w_btn_edge) begin
                        // Checked before the timeout so a press in the timeout
                        // cycle reports rt=TIMEOUT.
                        r_state <= S_DONE;
                        r_pre   <= PRE_TOP;
                        led     <= 1'b0;
                        done    <= 1'b1;
                        rt      <= r_rtc;
                    end else if (r_rtc == TIME_W'(TIMEOUT)) begin
                        r_state <= S_DONE;
                        r_pre   <= PRE_TOP;
                        led     <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        rt      <= '1;
                    end else if (w_tick) begin
                        r_rtc <= r_rtc + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_pre   <= PRE_TOP;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pre   <= PRE_TOP;
                    busy    <= 1'b0;
                    led     <= 1'b0;
                end
            endcase
        end
    end

`ifdef REFLEX_BEST_EN
    logic [TIME_W-1:0] r_best;
    logic              w_best_upd;

    assign w_best_upd = (r_state == S_LIGHT) && w_btn_edge;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_best <= '1;
        end else if (w_best_upd && (r_rtc < r_best)) begin
            r_best <= r_rtc;
        end
    end

    assign best_rt = r_best;
`else
    assign best_rt = '1;
`endif

endmodule
